operand_fetch_stage: RTL and testbench
======================================

Name: operand_fetch_stage

Overview:
Decode/operand-fetch pipeline stage that sits directly upstream of the 4x16 register file and downstream of instruction decode.
- Drives the RF read addresses and bypasses the same-cycle writeback value, which the RF cannot return because its write is clocked and its read is combinational.
- Muxes the immediate into operand B and stalls on pending-writer hazards.
- Latches a valid/ready pipeline register that feeds the execute stage.

Parameters:
DATA_W, 16, operand/register width
ADDR_W, 2, register address width (4 registers)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, synchronous, active-low
in_valid  input  1  decoded instruction valid
in_ready  output  1  stage accepts instruction this cycle
in_rs  input  ADDR_W  source A register
in_rt  input  ADDR_W  source B register
in_rd  input  ADDR_W  destination register
in_imm  input  DATA_W  sign-extended immediate
in_use_imm  input  1  operand B = in_imm, in_rt ignored
in_reg_write  input  1  instruction writes in_rd
in_is_load  input  1  instruction is a load
rf_addr_a  output  ADDR_W  RF read address A (= in_rs)
rf_addr_b  output  ADDR_W  RF read address B (= in_rt)
rf_data_a  input  DATA_W  RF read data A
rf_data_b  input  DATA_W  RF read data B
wb_write  input  1  writeback enable (same signal as RF write)
wb_addr  input  ADDR_W  writeback address
wb_data  input  DATA_W  writeback data
hz_pend_mask  input  4  bit i = register i has an in-flight writer not yet at writeback
flush  input  1  kill the held instruction (branch/jump redirect)
out_valid  output  1  execute-stage instruction valid
out_ready  input  1  execute stage accepts
out_a  output  DATA_W  operand A
out_b  output  DATA_W  operand B
out_rd  output  ADDR_W  destination
out_reg_write  output  1  writes destination
out_is_load  output  1  load

Behaviour:
- rf_addr_a/b are combinational copies of in_rs/in_rt.
- Bypass: opA = (wb_write && wb_addr==in_rs) ? wb_data : rf_data_a. opB uses the same rule on in_rt and rf_data_b, then opB = in_use_imm ? in_imm : opB.
- Hazard = in_valid && (hz_pend_mask[in_rs] || (!in_use_imm && hz_pend_mask[in_rt])).
- in_ready = (!out_valid || out_ready) && !hazard && !flush. It is combinational and never depends on out_valid being set in the same cycle.
- Transfer = in_valid && in_ready. On transfer, at the next edge: out_* <= bypassed operands and fields, out_valid <= 1.
- No transfer and out_ready: out_valid <= 0. Data registers hold their values and are don't-care.
- No transfer and !out_ready: hold everything; out_* are stable while out_valid && !out_ready.
- flush: out_valid <= 0 at the next edge. Flush has priority over transfer; no instruction is accepted in a flush cycle.
- Reset (!reset_n at the edge): out_valid, out_a, out_b, out_rd, out_reg_write, out_is_load <= 0. Reset overrides flush and transfer. in_ready stays low during the reset cycle because no edge with a transfer is honoured.
- Reset mid-stall discards the held instruction.
- Latency: 1 cycle from transfer to out_valid. Full throughput of 1 instruction/cycle with out_ready high and no hazard.
- A wb write to the same register as both in_rs and in_rt bypasses both operands.
- The stage never reads an operand later than its transfer cycle. Writers after that point are the caller's responsibility via hz_pend_mask.

Optional Feature:
OF_STALL_CNT_EN
- Defined: adds output stall_cnt [15:0]. It increments each cycle in_valid && !in_ready && !flush, saturates at 16'hFFFF and resets to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/include constants: DATA_W, ADDR_W, NUM_REGS=4. These sit alongside the existing opcode/constant includes.
- One natural combinational sub-module, operand_bypass, which performs the RF-vs-writeback select.
- operand_bypass is instantiated twice (A, B); the immediate mux and pipeline register stay in the top.

Test Plan:
1. Reset with reset_n=0 for 2 cycles, in_valid=1 -> out_valid=0, out_a=out_b=0; in_valid=1 on the first cycle after release -> out_valid=1 next cycle.
2. RF r1=16'h1234, wb_write=1 wb_addr=1 wb_data=16'hBEEF, in_rs=1 in_rt=1 -> out_a=out_b=16'hBEEF.
3. in_use_imm=1 in_imm=16'hFFF8, in_rt=2 with hz_pend_mask=4'b0100 -> no stall, out_b=16'hFFF8.
4. hz_pend_mask=4'b0010, in_rs=1 for 3 cycles then mask=0 -> in_ready=0 for 3 cycles, transfer on the 4th; with OF_STALL_CNT_EN, stall_cnt=3.
5. out_ready=0 while out_valid=1, new in_valid=1 -> in_ready=0, out_a/out_b unchanged until out_ready=1; back-to-back transfers follow with no bubble.
6. flush=1 with out_valid=1 and in_valid=1 -> next cycle out_valid=0, input not accepted.

Source files
------------

// File: rtl/operand_fetch_stage_pkg.sv
// Shared constants and the execute-stage payload type for the operand fetch stage.
// Optional build macro used across these files: OF_STALL_CNT_EN (adds stall_cnt).
package operand_fetch_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 2;
  localparam int NUM_REGS = 4;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              is_load;
  } exec_pkt_t;

endpackage

// File: rtl/operand_fetch_stage_if.sv
// Bus bundle between decode, register file, writeback, hazard unit and execute.
// stall_cnt exists only when OF_STALL_CNT_EN is defined.
// Handshake: a beat moves on either side only in a cycle where valid && ready are both high at the clock edge.
interface operand_fetch_stage_if;

  logic                                       in_valid;
  logic                                       in_ready;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] in_rs;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] in_rt;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] in_rd;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] in_imm;
  logic                                       in_use_imm;
  logic                                       in_reg_write;
  logic                                       in_is_load;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] rf_addr_a;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] rf_addr_b;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] rf_data_a;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] rf_data_b;
  logic                                       wb_write;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] wb_addr;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] wb_data;
  logic [operand_fetch_stage_pkg::NUM_REGS-1:0] hz_pend_mask;
  logic                                       flush;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] out_a;
  logic [operand_fetch_stage_pkg::DATA_W-1:0] out_b;
  logic [operand_fetch_stage_pkg::ADDR_W-1:0] out_rd;
  logic                                       out_reg_write;
  logic                                       out_is_load;
`ifdef OF_STALL_CNT_EN
  logic [15:0]                                stall_cnt;
`endif

  modport slave (
`ifdef OF_STALL_CNT_EN
    output stall_cnt,
`endif
    input  in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_reg_write, in_is_load,
    input  rf_data_a, rf_data_b, wb_write, wb_addr, wb_data, hz_pend_mask, flush, out_ready,
    output in_ready, rf_addr_a, rf_addr_b,
    output out_valid, out_a, out_b, out_rd, out_reg_write, out_is_load
  );

  modport master (
`ifdef OF_STALL_CNT_EN
    input  stall_cnt,
`endif
    output in_valid, in_rs, in_rt, in_rd, in_imm, in_use_imm, in_reg_write, in_is_load,
    output rf_data_a, rf_data_b, wb_write, wb_addr, wb_data, hz_pend_mask, flush, out_ready,
    input  in_ready, rf_addr_a, rf_addr_b,
    input  out_valid, out_a, out_b, out_rd, out_reg_write, out_is_load
  );

endinterface

// File: rtl/operand_fetch_stage_bypass.sv
// Register-file vs same-cycle writeback select for one source operand.
// Needed because the RF write is clocked while its read is combinational.
module operand_bypass
  import operand_fetch_stage_pkg::*;
(
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] op_data
);

  assign op_data = (wb_write && (wb_addr == src_addr)) ? wb_data : rf_data;

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: RF addressing, writeback bypass, immediate select, hazard stall
// and a valid/ready register into execute. OF_STALL_CNT_EN adds a saturating stall counter.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
(
  input logic            clk,
  input logic            reset_n,
  operand_fetch_stage_if.slave ofs
);

  logic [DATA_W-1:0] byp_a;
  logic [DATA_W-1:0] byp_b;
  logic [DATA_W-1:0] op_b;
  logic              hazard;
  logic              in_ready;
  logic              transfer;
  exec_pkt_t         out_pkt_d;
  exec_pkt_t         out_pkt_q;
  logic              out_valid_d;
  logic              out_valid_q;

  assign ofs.rf_addr_a = ofs.in_rs;
  assign ofs.rf_addr_b = ofs.in_rt;

  operand_bypass u_bypass_a (
    .src_addr (ofs.in_rs),
    .rf_data  (ofs.rf_data_a),
    .wb_write (ofs.wb_write),
    .wb_addr  (ofs.wb_addr),
    .wb_data  (ofs.wb_data),
    .op_data  (byp_a)
  );

  operand_bypass u_bypass_b (
    .src_addr (ofs.in_rt),
    .rf_data  (ofs.rf_data_b),
    .wb_write (ofs.wb_write),
    .wb_addr  (ofs.wb_addr),
    .wb_data  (ofs.wb_data),
    .op_data  (byp_b)
  );

  assign op_b = ofs.in_use_imm ? ofs.in_imm : byp_b;

  // rt is not a real source when the immediate replaces operand B.
  assign hazard   = ofs.in_valid &&
                    (ofs.hz_pend_mask[ofs.in_rs] || (!ofs.in_use_imm && ofs.hz_pend_mask[ofs.in_rt]));
  assign in_ready = reset_n && (!out_valid_q || ofs.out_ready) && !hazard && !ofs.flush;
  assign transfer = ofs.in_valid && in_ready;

  assign ofs.in_ready = in_ready;

  always_comb begin
    out_pkt_d   = out_pkt_q;
    out_valid_d = out_valid_q;
    if (ofs.flush) begin
      out_valid_d = 1'b0;
    end else if (transfer) begin
      out_valid_d         = 1'b1;
      out_pkt_d.a         = byp_a;
      out_pkt_d.b         = op_b;
      out_pkt_d.rd        = ofs.in_rd;
      out_pkt_d.reg_write = ofs.in_reg_write;
      out_pkt_d.is_load   = ofs.in_is_load;
    end else if (ofs.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_pkt_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_pkt_q   <= out_pkt_d;
    end
  end

  assign ofs.out_valid     = out_valid_q;
  assign ofs.out_a         = out_pkt_q.a;
  assign ofs.out_b         = out_pkt_q.b;
  assign ofs.out_rd        = out_pkt_q.rd;
  assign ofs.out_reg_write = out_pkt_q.reg_write;
  assign ofs.out_is_load   = out_pkt_q.is_load;

`ifdef OF_STALL_CNT_EN
  logic [15:0] stall_cnt_d;
  logic [15:0] stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ofs.in_valid && !in_ready && !ofs.flush && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ofs.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: directed scenarios plus randomized traffic against a
// queue-based occupancy model of the execute register and a clocked register file model.
module tb_operand_fetch_stage;

  localparam int PKT_W = 36;

  logic clk;
  logic reset_n;
  int   chk_cnt;
  int   pass_cnt;

  logic [15:0]      rf_mem [4];
  logic [PKT_W-1:0] exp_q [$];
  logic [15:0]      m_stall;

  operand_fetch_stage_if ofs_if ();

  operand_fetch_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ofs     (ofs_if)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // environment register file: clocked write, combinational read
  always @(posedge clk) begin
    if (ofs_if.wb_write) rf_mem[ofs_if.wb_addr] <= ofs_if.wb_data;
  end
  assign ofs_if.rf_data_a = rf_mem[ofs_if.rf_addr_a];
  assign ofs_if.rf_data_b = rf_mem[ofs_if.rf_addr_b];

  // driver tasks
  task automatic set_instr(input logic v, input logic [1:0] rs, input logic [1:0] rt,
                           input logic [1:0] rd, input logic [15:0] imm, input logic use_imm,
                           input logic rw, input logic ld);
    ofs_if.in_valid     = v;
    ofs_if.in_rs        = rs;
    ofs_if.in_rt        = rt;
    ofs_if.in_rd        = rd;
    ofs_if.in_imm       = imm;
    ofs_if.in_use_imm   = use_imm;
    ofs_if.in_reg_write = rw;
    ofs_if.in_is_load   = ld;
  endtask

  task automatic set_env(input logic wbw, input logic [1:0] wba, input logic [15:0] wbd,
                         input logic [3:0] mask, input logic fl, input logic ordy);
    ofs_if.wb_write     = wbw;
    ofs_if.wb_addr      = wba;
    ofs_if.wb_data      = wbd;
    ofs_if.hz_pend_mask = mask;
    ofs_if.flush        = fl;
    ofs_if.out_ready    = ordy;
  endtask

  task automatic chk(input string name, input logic [PKT_W-1:0] act, input logic [PKT_W-1:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // One cycle: check combinational and registered outputs against the model, then advance.
  task automatic tick();
    logic        hz;
    logic        exp_rdy;
    logic [15:0] a;
    logic [15:0] b;
    #2;
    hz = ofs_if.in_valid && (ofs_if.hz_pend_mask[ofs_if.in_rs] ||
                             (!ofs_if.in_use_imm && ofs_if.hz_pend_mask[ofs_if.in_rt]));
    exp_rdy = reset_n && (exp_q.size() == 0 || ofs_if.out_ready) && !hz && !ofs_if.flush;
    chk("in_ready", {35'd0, ofs_if.in_ready}, {35'd0, exp_rdy});
    chk("rf_addrs", {32'd0, ofs_if.rf_addr_a, ofs_if.rf_addr_b}, {32'd0, ofs_if.in_rs, ofs_if.in_rt});
    chk("out_valid", {35'd0, ofs_if.out_valid}, {35'd0, exp_q.size() != 0});
    if (exp_q.size() != 0)
      chk("out_pkt", {ofs_if.out_a, ofs_if.out_b, ofs_if.out_rd, ofs_if.out_reg_write, ofs_if.out_is_load},
          exp_q[0]);
`ifdef OF_STALL_CNT_EN
    chk("stall_cnt", {20'd0, ofs_if.stall_cnt}, {20'd0, m_stall});
`endif
    a = (ofs_if.wb_write && ofs_if.wb_addr == ofs_if.in_rs) ? ofs_if.wb_data : rf_mem[ofs_if.in_rs];
    b = (ofs_if.wb_write && ofs_if.wb_addr == ofs_if.in_rt) ? ofs_if.wb_data : rf_mem[ofs_if.in_rt];
    if (ofs_if.in_use_imm) b = ofs_if.in_imm;
    if (!reset_n) begin
      exp_q.delete();
      m_stall = 16'd0;
    end else if (ofs_if.flush) begin
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && ofs_if.out_ready) void'(exp_q.pop_front());
      if (ofs_if.in_valid && exp_rdy)
        exp_q.push_back({a, b, ofs_if.in_rd, ofs_if.in_reg_write, ofs_if.in_is_load});
      if (ofs_if.in_valid && !exp_rdy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    set_instr(1'b0, 2'd0, 2'd0, 2'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    set_env(1'b0, 2'd0, 16'd0, 4'd0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_instr(1'b1, 2'd1, 2'd2, 2'd3, 16'h5A5A, 1'b0, 1'b1, 1'b0);
    set_env(1'b0, 2'd0, 16'd0, 4'd0, 1'b0, 1'b1);
    exp_q.delete();
    m_stall = 16'd0;
    // preload the register file while reset is held
    for (int i = 0; i < 4; i++) begin
      ofs_if.wb_write = 1'b1;
      ofs_if.wb_addr  = 2'(i);
      ofs_if.wb_data  = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    ofs_if.wb_write = 1'b0;
    tick();
    chk("reset_out_valid", {35'd0, ofs_if.out_valid}, 36'd0);
    chk("reset_out_ab", {ofs_if.out_a, ofs_if.out_b, 4'd0}, 36'd0);
    chk("reset_out_fields", {32'd0, ofs_if.out_rd, ofs_if.out_reg_write, ofs_if.out_is_load}, 36'd0);
    reset_n = 1'b1;
    tick();
    chk("post_reset_valid", {35'd0, ofs_if.out_valid}, 36'd1);
    idle();
    tick();
  endtask

  task automatic test_bypass();
    idle();
    set_env(1'b1, 2'd1, 16'h1234, 4'd0, 1'b0, 1'b1);
    tick();
    set_instr(1'b1, 2'd1, 2'd1, 2'd2, 16'd0, 1'b0, 1'b1, 1'b0);
    set_env(1'b1, 2'd1, 16'hBEEF, 4'd0, 1'b0, 1'b1);
    tick();
    chk("bypass_both", {ofs_if.out_a, ofs_if.out_b, 4'd0}, {16'hBEEF, 16'hBEEF, 4'd0});
    idle();
    tick();
  endtask

  task automatic test_imm();
    idle();
    set_instr(1'b1, 2'd0, 2'd2, 2'd3, 16'hFFF8, 1'b1, 1'b1, 1'b0);
    set_env(1'b0, 2'd0, 16'd0, 4'b0100, 1'b0, 1'b1);
    tick();
    chk("imm_out_b", {20'd0, ofs_if.out_b}, {20'd0, 16'hFFF8});
    idle();
    tick();
  endtask

  task automatic test_hazard();
    logic [15:0] start_cnt;
    idle();
    start_cnt = m_stall;
    set_instr(1'b1, 2'd1, 2'd0, 2'd2, 16'd0, 1'b0, 1'b1, 1'b1);
    ofs_if.hz_pend_mask = 4'b0010;
    for (int i = 0; i < 3; i++) tick();
    ofs_if.hz_pend_mask = 4'b0000;
    tick();
    chk("hazard_release_valid", {35'd0, ofs_if.out_valid}, 36'd1);
`ifdef OF_STALL_CNT_EN
    chk("hazard_stall_cnt", {20'd0, ofs_if.stall_cnt - start_cnt}, {20'd0, 16'd3});
`endif
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    set_instr(1'b1, 2'($urandom), 2'($urandom), 2'd1, 16'd0, 1'b0, 1'b1, 1'b0);
    tick();
    ofs_if.out_ready = 1'b0;
    set_instr(1'b1, 2'($urandom), 2'($urandom), 2'd3, 16'h7777, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    ofs_if.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_instr(1'b1, 2'($urandom), 2'($urandom), 2'($urandom), 16'($urandom), 1'($urandom),
                1'b1, 1'b0);
      tick();
      chk("b2b_no_bubble", {35'd0, ofs_if.out_valid}, 36'd1);
    end
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    set_instr(1'b1, 2'd2, 2'd3, 2'd1, 16'd0, 1'b0, 1'b1, 1'b0);
    tick();
    ofs_if.flush     = 1'b1;
    ofs_if.out_ready = 1'b0;
    set_instr(1'b1, 2'd0, 2'd1, 2'd2, 16'd0, 1'b0, 1'b1, 1'b0);
    tick();
    chk("flush_kill", {35'd0, ofs_if.out_valid}, 36'd0);
    idle();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset_n = ($urandom_range(0, 59) != 0);
      set_instr(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom), 2'($urandom),
                16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      set_env(1'($urandom), 2'($urandom), 16'($urandom),
              ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      tick();
    end
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset();
    test_bypass();
    test_imm();
    test_hazard();
    test_back_to_back();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
